lcd_msg_sequencer: RTL and testbench
====================================

LCD_MSG_SEQUENCER -- requirements
Module: lcd_msg_sequencer

Interface
REQ-001 Parameter COLS, default 16: characters per row, legal range 1..16.
REQ-002 Parameter ROWS, default 2: display rows, legal range 1..2.
REQ-003 Parameter START_DELAY_CYC, default 50_000_000: idle cycles between start and the first character.
REQ-004 Parameter CHAR_GAP_CYC, default 50_000: cycles inserted after each character completes.
REQ-005 Parameter REFRESH_GAP_CYC, default 5_000_000: cycles between frames in continuous mode.
REQ-006 Port list, in order (name, direction, width, meaning):
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  begin a frame while IDLE.
- mode  in  1  0 = one-shot, 1 = continuous refresh.
- buf_we  in  1  frame-buffer write strobe.
- buf_addr  in  5  buffer index = row*16 + col.
- buf_wdata  in  8  ASCII character.
- lcd_ready  in  1  controller idle/ready.
- char_data  out  8  character to controller.
- cursor_pos  out  5  controller position.
- write_enable  out  1  one-cycle write pulse.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse at frame end.

Function
REQ-007 The frame buffer SHALL hold 32 8-bit entries; an entry is valid iff row < ROWS and col < COLS.
- buf_we with a valid address SHALL write the entry on the next clock edge.
- buf_we with an invalid address SHALL be ignored.
REQ-008 The states SHALL be IDLE, PRE, WAIT_RDY, ISSUE, SETTLE, GAP, REFRESH.
REQ-009 IDLE, start = 1: the block SHALL load the counter with START_DELAY_CYC, set index = 0 and go to PRE; start in any other state SHALL be ignored.
REQ-010 PRE, GAP and REFRESH SHALL each decrement the counter and exit when it reads 0; a count of 0 SHALL give a one-cycle stay.
REQ-011 WAIT_RDY SHALL go to ISSUE on the first cycle lcd_ready = 1, and SHALL wait indefinitely otherwise.
REQ-012 In ISSUE, for exactly one cycle, the block SHALL drive:
- write_enable = 1;
- char_data = buffer[index], read in that cycle;
- cursor_pos = index.
REQ-013 char_data and cursor_pos SHALL hold their values until the next ISSUE.
REQ-014 If a buffer write to the same address lands in the ISSUE cycle, char_data SHALL carry the old value.
REQ-015 SETTLE SHALL last one cycle minimum, then wait for lcd_ready = 1, then load CHAR_GAP_CYC and go to GAP.
REQ-016 GAP exit SHALL step index in row-major order over valid entries only:
- col = COLS-1 SHALL wrap to col 0 of the next row;
- the last valid entry SHALL end the frame.
REQ-017 At frame end the block SHALL pulse frame_done for one cycle and sample mode:
- mode = 1: load REFRESH_GAP_CYC, go to REFRESH, then restart at index 0 in WAIT_RDY;
- mode = 0: go to IDLE.
REQ-018 A mode change mid-frame SHALL take effect only at frame end.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 Counters SHALL be 32 bits wide; index arithmetic SHALL be modulo 32.
REQ-021 Timing: start sampled at cycle t, START_DELAY_CYC = 0, lcd_ready held at 1 -> write_enable SHALL be high in cycle t+3.

Reset
REQ-022 rst = 1 at a clock edge SHALL force:
- state = IDLE;
- write_enable = 0, frame_done = 0, busy = 0;
- char_data = 0x00, cursor_pos = 0, index = 0, counter = 0;
- every buffer entry = 0x20.
REQ-023 rst asserted mid-frame SHALL abort the frame on the next edge, with no further write_enable and no frame_done.
REQ-024 rst SHALL take priority over start and buf_we in the same cycle.

Verification
REQ-025 Scenario: COLS=16, ROWS=2, write "HI" at addresses 0..1 and "OK" at 16..17, start, mode=0, lcd_ready=1 -> exactly 32 write_enable pulses; (cursor_pos, char_data) = (0,0x48), (1,0x49), (2..15,0x20), (16,0x4F), (17,0x4B), ...; one frame_done; then IDLE with busy=0.
REQ-026 Scenario: COLS=4, ROWS=1, start, lcd_ready low for 100 cycles before each character -> each pulse occurs only after lcd_ready returns to 1; cursor_pos sequence 0,1,2,3; no pulse while lcd_ready = 0.
REQ-027 Scenario: mode=1, REFRESH_GAP_CYC=10, buffer[5] changed from 0x41 to 0x42 during frame 1 after index 5 was sent -> frame 1 sends 0x41 at position 5; frame 2 sends 0x42; frame_done pulses once per frame.
REQ-028 Scenario: mode cleared midway through frame 2 -> frame 2 completes; frame_done pulses; then IDLE.
REQ-029 Scenario: rst during GAP after index 7 -> busy=0 next cycle; no further write_enable; all buffer entries read 0x20.
REQ-030 Scenario: start pulsed while busy, and buf_we to address 20 with ROWS=1 -> frame unaffected; buffer unchanged.

Source files
------------

// File: rtl/lcd_msg_sequencer.sv
// lcd_msg_sequencer
//   Streams a 32-entry character frame buffer to a character-LCD controller.
//   Each character goes through a ready handshake, then a one-cycle write pulse,
//   then a settle/ready wait and a gap. A frame may run once or repeat.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   start             begin a frame (only honoured while idle)
//   mode              0 = one-shot, 1 = continuous refresh (sampled at frame end)
//   buf_we/addr/wdata frame-buffer write port, addr = row*16 + col
//   lcd_ready         controller ready
//   char_data         character presented to the controller
//   cursor_pos        position presented to the controller
//   write_enable      one-cycle write strobe
//   busy              high whenever a frame is in progress
//   frame_done        one-cycle pulse when the last character finishes
module lcd_msg_sequencer #(
    parameter int unsigned COLS            = 16,
    parameter int unsigned ROWS            = 2,
    parameter int unsigned START_DELAY_CYC = 50_000_000,
    parameter int unsigned CHAR_GAP_CYC    = 50_000,
    parameter int unsigned REFRESH_GAP_CYC = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mode,
    input  logic       buf_we,
    input  logic [4:0] buf_addr,
    input  logic [7:0] buf_wdata,
    input  logic       lcd_ready,
    output logic [7:0] char_data,
    output logic [4:0] cursor_pos,
    output logic       write_enable,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        WAIT_RDY,
        ISSUE,
        SETTLE,
        GAP,
        REFRESH
    } state_t;

    localparam logic [3:0] LAST_COL = 4'(COLS - 1);
    localparam logic       LAST_ROW = 1'(ROWS - 1);

    state_t      state, state_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic [4:0]  idx, idx_nxt;
    logic [7:0]  mem [32];
    logic [7:0]  char_hold;
    logic [4:0]  pos_hold;
    logic        last_col;
    logic        last_entry;
    logic        addr_ok;

    assign last_col   = (idx[3:0] == LAST_COL);
    assign last_entry = last_col && (idx[4] == LAST_ROW);
    assign addr_ok    = (buf_addr[3:0] <= LAST_COL) && (buf_addr[4] <= LAST_ROW);

    // The buffer is read combinationally in the ISSUE cycle, so a write landing
    // at the end of that cycle is not seen until the next frame. Outside ISSUE
    // the last issued character/position are held.
    assign char_data  = (state == ISSUE) ? mem[idx] : char_hold;
    assign cursor_pos = (state == ISSUE) ? idx      : pos_hold;
    assign busy       = (state != IDLE);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        idx_nxt      = idx;
        write_enable = 1'b0;
        frame_done   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    cnt_nxt   = START_DELAY_CYC;
                    idx_nxt   = 5'd0;
                    state_nxt = PRE;
                end
            end
            PRE: begin
                if (cnt == 32'd0) state_nxt = WAIT_RDY;
                else              cnt_nxt   = cnt - 32'd1;
            end
            WAIT_RDY: begin
                if (lcd_ready) state_nxt = ISSUE;
            end
            ISSUE: begin
                write_enable = 1'b1;
                state_nxt    = SETTLE;
            end
            SETTLE: begin
                if (lcd_ready) begin
                    cnt_nxt   = CHAR_GAP_CYC;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (cnt != 32'd0) begin
                    cnt_nxt = cnt - 32'd1;
                end else if (last_entry) begin
                    frame_done = 1'b1;
                    idx_nxt    = 5'd0;
                    if (mode) begin
                        cnt_nxt   = REFRESH_GAP_CYC;
                        state_nxt = REFRESH;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (last_col) begin
                    // jump to column 0 of the next row (row stride is 16)
                    idx_nxt   = (idx & 5'h10) + 5'd16;
                    state_nxt = WAIT_RDY;
                end else begin
                    idx_nxt   = idx + 5'd1;
                    state_nxt = WAIT_RDY;
                end
            end
            REFRESH: begin
                if (cnt == 32'd0) state_nxt = WAIT_RDY;
                else              cnt_nxt   = cnt - 32'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 32'd0;
            idx       <= 5'd0;
            char_hold <= 8'h00;
            pos_hold  <= 5'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            if (state == ISSUE) begin
                char_hold <= mem[idx];
                pos_hold  <= idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'h20;
        end else if (buf_we && addr_ok) begin
            mem[buf_addr] <= buf_wdata;
        end
    end

endmodule

// File: tb/tb_lcd_msg_sequencer.sv
// Testbench for lcd_msg_sequencer: two instances (16x2 and 4x1) driven by one
// directed sequence, with a scoreboard of expected (position, character) writes.
module tb_lcd_msg_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       a_start, a_mode, a_buf_we, a_rdy;
    logic [4:0] a_buf_addr;
    logic [7:0] a_buf_wdata;
    logic [7:0] a_char;
    logic [4:0] a_pos;
    logic       a_we, a_busy, a_fd;

    logic       b_start, b_mode, b_buf_we, b_rdy;
    logic [4:0] b_buf_addr;
    logic [7:0] b_buf_wdata;
    logic [7:0] b_char;
    logic [4:0] b_pos;
    logic       b_we, b_busy, b_fd;

    lcd_msg_sequencer #(
        .COLS(16), .ROWS(2), .START_DELAY_CYC(3), .CHAR_GAP_CYC(2), .REFRESH_GAP_CYC(10)
    ) u_a (
        .clk(clk), .rst(rst), .start(a_start), .mode(a_mode),
        .buf_we(a_buf_we), .buf_addr(a_buf_addr), .buf_wdata(a_buf_wdata),
        .lcd_ready(a_rdy), .char_data(a_char), .cursor_pos(a_pos),
        .write_enable(a_we), .busy(a_busy), .frame_done(a_fd)
    );

    lcd_msg_sequencer #(
        .COLS(4), .ROWS(1), .START_DELAY_CYC(0), .CHAR_GAP_CYC(2), .REFRESH_GAP_CYC(10)
    ) u_b (
        .clk(clk), .rst(rst), .start(b_start), .mode(b_mode),
        .buf_we(b_buf_we), .buf_addr(b_buf_addr), .buf_wdata(b_buf_wdata),
        .lcd_ready(b_rdy), .char_data(b_char), .cursor_pos(b_pos),
        .write_enable(b_we), .busy(b_busy), .frame_done(b_fd)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  a_mdl [32];
    logic [7:0]  b_mdl [32];
    logic [12:0] a_q [$];
    logic [12:0] b_q [$];
    int a_we_cnt = 0, a_fd_cnt = 0, b_we_cnt = 0, b_fd_cnt = 0;
    logic b_rdy_q = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // scoreboard monitors
    always @(negedge clk) begin
        if (a_we) begin
            logic [12:0] e;
            a_we_cnt++;
            if (a_q.size() == 0) begin
                check("a_unexpected_we", 32'(a_we), 32'd0);
            end else begin
                e = a_q.pop_front();
                check("a_pos", 32'(a_pos), 32'(e[12:8]));
                check("a_char", 32'(a_char), 32'(e[7:0]));
            end
        end
        if (a_fd) a_fd_cnt++;
    end

    always @(posedge clk) b_rdy_q <= b_rdy;

    always @(negedge clk) begin
        if (b_we) begin
            logic [12:0] e;
            b_we_cnt++;
            check("b_rdy_before_we", 32'(b_rdy_q), 32'd1);
            if (b_q.size() == 0) begin
                check("b_unexpected_we", 32'(b_we), 32'd0);
            end else begin
                e = b_q.pop_front();
                check("b_pos", 32'(b_pos), 32'(e[12:8]));
                check("b_char", 32'(b_char), 32'(e[7:0]));
            end
        end
        if (b_fd) b_fd_cnt++;
    end

    task automatic a_write(input logic [4:0] ad, input logic [7:0] d);
        a_buf_we = 1'b1; a_buf_addr = ad; a_buf_wdata = d;
        a_mdl[ad] = d;
        @(negedge clk);
        a_buf_we = 1'b0;
    endtask

    task automatic b_write(input logic [4:0] ad, input logic [7:0] d);
        b_buf_we = 1'b1; b_buf_addr = ad; b_buf_wdata = d;
        if (ad[4] == 1'b0 && ad[3:0] < 4'd4) b_mdl[ad] = d;
        @(negedge clk);
        b_buf_we = 1'b0;
    endtask

    task automatic a_push(input int n);
        for (int i = 0; i < n; i++) a_q.push_back({5'(i), a_mdl[i]});
    endtask

    task automatic b_push();
        for (int i = 0; i < 4; i++) b_q.push_back({5'(i), b_mdl[i]});
    endtask

    task automatic a_pulse_start();
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic wait_a_fd(input int maxc, input string tag);
        int k = 0;
        do begin @(negedge clk); k++; end while (!a_fd && k < maxc);
        check(tag, 32'(a_fd), 32'd1);
    endtask

    task automatic wait_b_fd(input int maxc, input string tag);
        int k = 0;
        do begin @(negedge clk); k++; end while (!b_fd && k < maxc);
        check(tag, 32'(b_fd), 32'd1);
    endtask

    task automatic wait_a_we_at(input logic [4:0] p, input int maxc, input string tag);
        int k = 0;
        do begin @(negedge clk); k++; end while (!(a_we && a_pos == p) && k < maxc);
        check(tag, 32'(a_we && a_pos == p), 32'd1);
    endtask

    task automatic wait_b_we(input int maxc, input string tag);
        int k = 0;
        do begin @(negedge clk); k++; end while (!b_we && k < maxc);
        check(tag, 32'(b_we), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        a_start = 1'b0; a_mode = 1'b0; a_buf_we = 1'b0; a_buf_addr = 5'd0; a_buf_wdata = 8'd0; a_rdy = 1'b1;
        b_start = 1'b0; b_mode = 1'b0; b_buf_we = 1'b0; b_buf_addr = 5'd0; b_buf_wdata = 8'd0; b_rdy = 1'b1;
        for (int i = 0; i < 32; i++) begin a_mdl[i] = 8'h20; b_mdl[i] = 8'h20; end
        repeat (3) @(negedge clk);
        check("rst_a_busy", 32'(a_busy), 32'd0);
        check("rst_a_we", 32'(a_we), 32'd0);
        check("rst_a_fd", 32'(a_fd), 32'd0);
        check("rst_a_char", 32'(a_char), 32'h00);
        check("rst_a_pos", 32'(a_pos), 32'd0);
        check("rst_b_busy", 32'(b_busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 4x1: load "ABCD"; out-of-range writes (addr 20, addr 4) must be dropped
        b_write(5'd0, 8'h41); b_write(5'd1, 8'h42); b_write(5'd2, 8'h43); b_write(5'd3, 8'h44);
        b_write(5'd20, 8'h5A); b_write(5'd4, 8'h59);
        b_push();
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        check("b_lat_cyc1", 32'(b_we), 32'd0);
        @(negedge clk);
        check("b_lat_cyc2", 32'(b_we), 32'd0);
        @(negedge clk);
        check("b_lat_cyc3", 32'(b_we), 32'd1);
        check("b_busy_in_frame", 32'(b_busy), 32'd1);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        wait_b_fd(200, "b1_fd_seen");
        repeat (5) @(negedge clk);
        check("b1_busy_after", 32'(b_busy), 32'd0);
        check("b1_we_count", 32'(b_we_cnt), 32'd4);
        check("b1_fd_count", 32'(b_fd_cnt), 32'd1);
        check("b1_queue_left", 32'(b_q.size()), 32'd0);

        // 4x1: controller not ready for 100 cycles before each character
        b_rdy = 1'b0;
        b_push();
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            repeat (100) @(negedge clk);
            check("b2_no_we_while_low", 32'(b_we_cnt), 32'(4 + c));
            b_rdy = 1'b1;
            wait_b_we(20, "b2_we_seen");
            check("b2_pos", 32'(b_pos), 32'(c));
            b_rdy = 1'b0;
        end
        b_rdy = 1'b1;
        wait_b_fd(50, "b2_fd_seen");
        repeat (3) @(negedge clk);
        check("b2_we_count", 32'(b_we_cnt), 32'd8);
        check("b2_fd_count", 32'(b_fd_cnt), 32'd2);
        check("b2_busy_after", 32'(b_busy), 32'd0);

        // 16x2 one-shot: "HI" on row 0, "OK" on row 1
        a_write(5'd0, 8'h48); a_write(5'd1, 8'h49); a_write(5'd16, 8'h4F); a_write(5'd17, 8'h4B);
        a_mode = 1'b0;
        a_push(32);
        a_pulse_start();
        wait_a_fd(400, "a1_fd_seen");
        repeat (3) @(negedge clk);
        check("a1_we_count", 32'(a_we_cnt), 32'd32);
        check("a1_fd_count", 32'(a_fd_cnt), 32'd1);
        check("a1_busy_after", 32'(a_busy), 32'd0);
        check("a1_queue_left", 32'(a_q.size()), 32'd0);

        // 16x2 continuous: entry 5 rewritten in the very cycle it is issued
        a_write(5'd5, 8'h41);
        a_mode = 1'b1;
        a_push(32);
        a_pulse_start();
        wait_a_we_at(5'd5, 100, "a2_we5_seen");
        a_write(5'd5, 8'h42);
        a_push(32);
        wait_a_fd(400, "a2_fd1_seen");
        @(negedge clk);
        check("a2_busy_refresh", 32'(a_busy), 32'd1);
        wait_a_we_at(5'd10, 200, "a2_f2_we10_seen");
        a_mode = 1'b0;
        wait_a_fd(400, "a2_fd2_seen");
        repeat (20) @(negedge clk);
        check("a2_busy_after", 32'(a_busy), 32'd0);
        check("a2_fd_count", 32'(a_fd_cnt), 32'd3);
        check("a2_we_count", 32'(a_we_cnt), 32'd96);
        check("a2_queue_left", 32'(a_q.size()), 32'd0);

        // reset during the gap after index 7; reset beats start and buf_we
        a_push(8);
        a_pulse_start();
        wait_a_we_at(5'd7, 100, "a3_we7_seen");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; a_start = 1'b1;
        a_buf_we = 1'b1; a_buf_addr = 5'd0; a_buf_wdata = 8'h51;
        @(negedge clk);
        rst = 1'b0; a_start = 1'b0; a_buf_we = 1'b0;
        check("a3_busy_after_rst", 32'(a_busy), 32'd0);
        check("a3_char_after_rst", 32'(a_char), 32'h00);
        check("a3_pos_after_rst", 32'(a_pos), 32'd0);
        for (int i = 0; i < 32; i++) a_mdl[i] = 8'h20;
        repeat (50) @(negedge clk);
        check("a3_we_count", 32'(a_we_cnt), 32'd104);
        check("a3_fd_count", 32'(a_fd_cnt), 32'd3);
        check("a3_busy_idle", 32'(a_busy), 32'd0);
        a_push(32);
        a_pulse_start();
        wait_a_fd(400, "a4_fd_seen");
        repeat (3) @(negedge clk);
        check("a4_we_count", 32'(a_we_cnt), 32'd136);
        check("a4_queue_left", 32'(a_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
